systolic_sequencer: RTL and testbench
=====================================

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter width_p, default 32, element width in bits (two's complement).
REQ-002 SHALL have parameter array_height_p, default 2, number of array rows (H).
REQ-003 SHALL have parameter array_width_p, default 2, number of array columns (W).
REQ-004 SHALL have parameter k_p, default 2, inner dimension (K).
REQ-005 SHALL have parameter timeout_p, default 16, maximum cycles spent in WAIT.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
- clk_i  in  1  clock; all state on rising edge
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  job request; accepted when start_i & ready_o
- ready_o  out  1  idle, able to accept a job
- a_i  in  width_p*H*K  matrix A; element (r,k) at index r+k*H
- b_i  in  width_p*K*W  matrix B; element (k,c) at index k+c*K
- en_o  out  1  array enable
- flush_o  out  H  array accumulator clear
- row_o  out  width_p*H  row lane data
- row_valid_o  out  H  row lane valid
- row_ready_i  in  H  row lane ready
- col_o  out  width_p*W  column lane data
- col_valid_o  out  W  column lane valid
- col_ready_i  in  W  column lane ready
- z_i  in  width_p*H*W  array results; (r,c) at index r+c*H
- z_valid_i  in  H*W  per-cell result valid
- z_yumi_o  out  H*W  result consume
- c_o  out  width_p*H*W  captured product C=A*B, same indexing as z_i
- c_valid_o  out  1  c_o valid
- c_yumi_i  in  1  consumer takes c_o
- err_o  out  1  sticky timeout flag

Function
REQ-007 SHALL implement states IDLE, FLUSH, FEED, WAIT, DRAIN, DONE.
REQ-008 IDLE: ready_o=1; on start_i, SHALL register a_i and b_i, clear err_o, step counter t=0, and go to FLUSH.
REQ-009 FLUSH: SHALL drive flush_o all ones for exactly one cycle, then go to FEED.
REQ-010 FEED: row lane r SHALL present A[r][t-r] with valid=1 iff 0<=t-r<K; column lane c SHALL present B[t-c][c] with valid=1 iff 0<=t-c<K; inactive lanes SHALL drive data 0.
REQ-011 FEED: t SHALL advance only in a cycle where every asserted row_valid_o/col_valid_o bit has its ready bit high; otherwise outputs SHALL hold unchanged.
REQ-012 FEED SHALL run S=K+max(H,W)-1 steps; after step S-1 is accepted, it SHALL go to WAIT with all valids low.
REQ-013 WAIT: SHALL count cycles; when &z_valid_i, it SHALL go to DRAIN; if the count reaches timeout_p first, it SHALL set err_o and go to IDLE.
REQ-014 DRAIN: SHALL capture z_i into c_o and assert z_yumi_o all ones for exactly one cycle, then go to DONE.
REQ-015 DONE: SHALL hold c_valid_o=1 with c_o stable until c_yumi_i, then go to IDLE; c_valid_o SHALL fall in the cycle after c_yumi_i.
REQ-016 en_o SHALL be 1 in FLUSH, FEED, WAIT, DRAIN and 0 otherwise.
REQ-017 start_i outside IDLE SHALL be ignored; a_i/b_i changes after acceptance SHALL not affect the job.
REQ-018 With no stalls, the first FEED cycle SHALL be 2 cycles after the start_i acceptance edge.
REQ-019 The sequencer SHALL perform no arithmetic; c_o SHALL be z_i bit-exact.

Reset
REQ-020 On reset_i high at a clock edge, the block SHALL enter IDLE from any state, including mid-FEED and mid-DONE.
REQ-021 On reset, outputs SHALL be: ready_o=1; err_o, c_valid_o, en_o=0; flush_o, row_valid_o, col_valid_o, z_yumi_o all zero; row_o, col_o, c_o all zero.

Verification
REQ-022 H=W=K=2, A=[[13,45],[6,27]], B=[[83,9],[22,1]] -> feed t0: row_valid=01 (13), col_valid=01 (83); t1: 11 (45,6), 11 (22,9); t2: 10 (27), 10 (1); result c_o C=[[2069,162],[1092,81]].
REQ-023 A=[[-37,44],[10,960]], B=[[83,99],[22,-1]] -> C=[[-2103,-3707],[21950,30]], signed 32-bit.
REQ-024 col_ready_i[1]=0 for 3 cycles during t1 -> t stays 1, lanes hold 45/6/22/9, and the final C is unchanged.
REQ-025 z_valid_i held 0 -> err_o=1 after timeout_p=16 WAIT cycles, state returns to IDLE, and the next start_i clears err_o.
REQ-026 Reset asserted mid-FEED -> next cycle ready_o=1 and all valids 0; a fresh job gives a correct C.
REQ-027 c_yumi_i held low for 5 cycles in DONE -> c_valid_o and c_o stay stable, and start_i is ignored until the yumi.

Source files
------------

// File: rtl/systolic_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : systolic_sequencer
// Purpose  : Job sequencer for an H x W output-stationary systolic array.
//            Latches one A (H x K) / B (K x W) job, clears the array
//            accumulators, streams skewed operands into the row and column
//            lanes under per-lane valid/ready, waits for every cell to report
//            a result, captures the result matrix and hands it to a consumer.
// Ports    : clk_i / reset_i        clock, synchronous active-high reset
//            start_i / ready_o      job request / idle indication
//            a_i, b_i               operand matrices (element (r,k) at r+k*H,
//                                   element (k,c) at k+c*K)
//            en_o, flush_o          array enable, accumulator clear
//            row_o/_valid_o/_ready_i    row operand lanes
//            col_o/_valid_o/_ready_i    column operand lanes
//            z_i, z_valid_i, z_yumi_o   array results in, consume strobe out
//            c_o, c_valid_o, c_yumi_i   captured product out to consumer
//            err_o                  sticky result-wait timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module systolic_sequencer #(
    parameter int width_p        = 32,
    parameter int array_height_p = 2,
    parameter int array_width_p  = 2,
    parameter int k_p            = 2,
    parameter int timeout_p      = 16
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic                                            start_i,
    output logic                                            ready_o,
    input  logic [width_p*array_height_p*k_p-1:0]           a_i,
    input  logic [width_p*k_p*array_width_p-1:0]            b_i,
    output logic                                            en_o,
    output logic [array_height_p-1:0]                       flush_o,
    output logic [width_p*array_height_p-1:0]               row_o,
    output logic [array_height_p-1:0]                       row_valid_o,
    input  logic [array_height_p-1:0]                       row_ready_i,
    output logic [width_p*array_width_p-1:0]                col_o,
    output logic [array_width_p-1:0]                        col_valid_o,
    input  logic [array_width_p-1:0]                        col_ready_i,
    input  logic [width_p*array_height_p*array_width_p-1:0] z_i,
    input  logic [array_height_p*array_width_p-1:0]         z_valid_i,
    output logic [array_height_p*array_width_p-1:0]         z_yumi_o,
    output logic [width_p*array_height_p*array_width_p-1:0] c_o,
    output logic                                            c_valid_o,
    input  logic                                            c_yumi_i,
    output logic                                            err_o
);

    localparam int C_H      = array_height_p;
    localparam int C_W      = array_width_p;
    localparam int C_K      = k_p;
    localparam int C_HW     = C_H * C_W;
    localparam int C_MAX_HW = (C_H > C_W) ? C_H : C_W;
    // Number of feed steps needed for the last skewed operand to enter.
    localparam int C_STEPS  = C_K + C_MAX_HW - 1;
    localparam int C_T_W    = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
    localparam int C_CNT_W  = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [C_T_W-1:0]   C_T_LAST   = C_T_W'(C_STEPS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(timeout_p - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                          state_q,     state_d;
    logic [C_T_W-1:0]                t_q,         t_d;
    logic [C_CNT_W-1:0]              wcnt_q,      wcnt_d;
    logic [width_p*C_H*C_K-1:0]      a_q,         a_d;
    logic [width_p*C_K*C_W-1:0]      b_q,         b_d;
    logic [width_p*C_HW-1:0]         c_q,         c_d;
    logic                            c_valid_q,   c_valid_d;
    logic                            err_q,       err_d;
    logic                            ready_q,     ready_d;
    logic                            en_q,        en_d;
    logic [C_H-1:0]                  flush_q,     flush_d;
    logic [width_p*C_H-1:0]          row_q,       row_d;
    logic [C_H-1:0]                  row_valid_q, row_valid_d;
    logic [width_p*C_W-1:0]          col_q,       col_d;
    logic [C_W-1:0]                  col_valid_q, col_valid_d;
    logic [C_HW-1:0]                 z_yumi_q,    z_yumi_d;

    logic                            feed_fire;
    int                              t_int;
    int                              idx;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        wcnt_d      = wcnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        c_valid_d   = c_valid_q;
        err_d       = err_q;
        row_d       = '0;
        row_valid_d = '0;
        col_d       = '0;
        col_valid_d = '0;
        t_int       = 0;
        idx         = 0;

        // A step is taken only when no presented lane is back-pressured.
        feed_fire = ~|(row_valid_q & ~row_ready_i) && ~|(col_valid_q & ~col_ready_i);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    err_d   = 1'b0;
                    t_d     = '0;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                t_d     = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (feed_fire) begin
                    if (t_q == C_T_LAST) begin
                        wcnt_d  = '0;
                        state_d = ST_WAIT;
                    end else begin
                        t_d = t_q + C_T_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // Results take priority over a timeout landing in the same cycle.
                if (&z_valid_i) begin
                    c_d     = z_i;
                    state_d = ST_DRAIN;
                end else if (wcnt_q == C_CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + C_CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                c_valid_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (c_yumi_i) begin
                    c_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they appear registered
        // in the same cycle as the state they belong to.
        ready_d  = (state_d == ST_IDLE);
        en_d     = (state_d == ST_FLUSH) || (state_d == ST_FEED) ||
                   (state_d == ST_WAIT)  || (state_d == ST_DRAIN);
        flush_d  = {C_H{state_d == ST_FLUSH}};
        z_yumi_d = {C_HW{state_d == ST_DRAIN}};

        // Skewed operand presentation: lane r/c lags the step counter by its
        // own index so operands meet in the correct cell.
        if (state_d == ST_FEED) begin
            t_int = int'(t_d);
            for (int r = 0; r < C_H; r++) begin
                idx = t_int - r;
                if (idx >= 0 && idx < C_K) begin
                    row_d[r*width_p +: width_p] = a_d[(r + idx*C_H)*width_p +: width_p];
                    row_valid_d[r]              = 1'b1;
                end
            end
            for (int c = 0; c < C_W; c++) begin
                idx = t_int - c;
                if (idx >= 0 && idx < C_K) begin
                    col_d[c*width_p +: width_p] = b_d[(idx + c*C_K)*width_p +: width_p];
                    col_valid_d[c]              = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            wcnt_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            c_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            en_q        <= 1'b0;
            flush_q     <= '0;
            row_q       <= '0;
            row_valid_q <= '0;
            col_q       <= '0;
            col_valid_q <= '0;
            z_yumi_q    <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            wcnt_q      <= wcnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            c_valid_q   <= c_valid_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            en_q        <= en_d;
            flush_q     <= flush_d;
            row_q       <= row_d;
            row_valid_q <= row_valid_d;
            col_q       <= col_d;
            col_valid_q <= col_valid_d;
            z_yumi_q    <= z_yumi_d;
        end
    end

    assign ready_o     = ready_q;
    assign en_o        = en_q;
    assign flush_o     = flush_q;
    assign row_o       = row_q;
    assign row_valid_o = row_valid_q;
    assign col_o       = col_q;
    assign col_valid_o = col_valid_q;
    assign z_yumi_o    = z_yumi_q;
    assign c_o         = c_q;
    assign c_valid_o   = c_valid_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_systolic_sequencer
// Purpose  : Self-checking bench for systolic_sequencer (H=W=K=2, 32-bit).
//            Behavioural array model consumes the lanes and returns results;
//            expected products are queued at issue and checked on c_valid_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_sequencer;

    localparam int WD = 32;
    localparam int H  = 2;
    localparam int W  = 2;
    localparam int K  = 2;
    localparam int TO = 16;
    localparam int S  = K + ((H > W) ? H : W) - 1;

    logic                clk = 1'b0;
    logic                reset_i;
    logic                start_i;
    logic                ready_o;
    logic [WD*H*K-1:0]   a_i;
    logic [WD*K*W-1:0]   b_i;
    logic                en_o;
    logic [H-1:0]        flush_o;
    logic [WD*H-1:0]     row_o;
    logic [H-1:0]        row_valid_o;
    logic [H-1:0]        row_ready_i = '1;
    logic [WD*W-1:0]     col_o;
    logic [W-1:0]        col_valid_o;
    logic [W-1:0]        col_ready_i = '1;
    logic [WD*H*W-1:0]   z_i = '0;
    logic [H*W-1:0]      z_valid_i = '0;
    logic [H*W-1:0]      z_yumi_o;
    logic [WD*H*W-1:0]   c_o;
    logic                c_valid_o;
    logic                c_yumi_i = 1'b0;
    logic                err_o;

    systolic_sequencer #(
        .width_p(WD), .array_height_p(H), .array_width_p(W), .k_p(K), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .en_o(en_o), .flush_o(flush_o),
        .row_o(row_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
        .col_o(col_o), .col_valid_o(col_valid_o), .col_ready_i(col_ready_i),
        .z_i(z_i), .z_valid_i(z_valid_i), .z_yumi_o(z_yumi_o),
        .c_o(c_o), .c_valid_o(c_valid_o), .c_yumi_i(c_yumi_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Job description and controls owned by the stimulus process.
    int cur_a [H][K];
    int cur_b [K][W];
    int stall_mode = 0;   // 0 always ready, 1 random back-pressure, 2 col 1 stalled 3 cycles at t1
    bit suppress_z = 0;   // array never reports results
    int yumi_hold  = 0;   // cycles consumer waits before taking c_o

    logic [WD*H*W-1:0] sb_q [$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ctrl"}, {ready_o, err_o, c_valid_o, en_o}, 4'b1000);
        chk({nm, "_vec"},  {flush_o, row_valid_o, col_valid_o, z_yumi_o}, '0);
        chk({nm, "_row"},  row_o, '0);
        chk({nm, "_col"},  col_o, '0);
        chk({nm, "_c"},    c_o, '0);
    endtask

    function automatic int rnd_val();
        if ($urandom_range(3) == 0) return int'($urandom);
        return int'($urandom_range(2000)) - 1000;
    endfunction

    // ------------------------------------------------------------------
    // Array model: drives lane readies, checks every presented step against
    // the skew rule, accumulates what it actually received, reports results.
    // ------------------------------------------------------------------
    int steps = 0;
    bit zdone = 0;
    int zdelay = 0;
    int stall_used = 0;
    int rx_row [S][H];
    int rx_col [S][W];

    always @(negedge clk) begin : p_array
        logic [H-1:0]    erv;
        logic [W-1:0]    ecv;
        logic [WD*H-1:0] erow;
        logic [WD*W-1:0] ecol;
        bit fire;
        int idx;
        int acc;
        if (flush_o != '0) begin
            steps = 0; zdone = 0; stall_used = 0; z_valid_i = '0;
            zdelay = $urandom_range(4);
        end
        if (z_yumi_o != '0) z_valid_i = '0;
        row_ready_i = '1;
        col_ready_i = '1;
        if (stall_mode == 1) begin
            for (int i = 0; i < H; i++) row_ready_i[i] = ($urandom_range(3) != 0);
            for (int i = 0; i < W; i++) col_ready_i[i] = ($urandom_range(3) != 0);
        end else if (stall_mode == 2 && row_valid_o == '1 && col_valid_o == '1 && stall_used < 3) begin
            col_ready_i[1] = 1'b0;
            stall_used++;
        end
        if (row_valid_o != '0 || col_valid_o != '0) begin
            erv = '0; ecv = '0; erow = '0; ecol = '0;
            for (int r = 0; r < H; r++) begin
                idx = steps - r;
                if (idx >= 0 && idx < K) begin
                    erv[r] = 1'b1;
                    erow[r*WD +: WD] = cur_a[r][idx];
                end
            end
            for (int c = 0; c < W; c++) begin
                idx = steps - c;
                if (idx >= 0 && idx < K) begin
                    ecv[c] = 1'b1;
                    ecol[c*WD +: WD] = cur_b[idx][c];
                end
            end
            chk("lanes", {row_valid_o, col_valid_o, row_o, col_o}, {erv, ecv, erow, ecol});
            fire = ((row_valid_o & ~row_ready_i) == '0) && ((col_valid_o & ~col_ready_i) == '0);
            if (fire && reset_i !== 1'b1) begin
                if (steps < S) begin
                    for (int r = 0; r < H; r++) rx_row[steps][r] = row_valid_o[r] ? int'(row_o[r*WD +: WD]) : 0;
                    for (int c = 0; c < W; c++) rx_col[steps][c] = col_valid_o[c] ? int'(col_o[c*WD +: WD]) : 0;
                end
                steps++;
            end
        end
        if (steps == S && !zdone && !suppress_z) begin
            if (zdelay == 0) begin
                // Cell (r,c) meets row r at step r+k and column c at step c+k.
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++) begin
                        acc = 0;
                        for (int k = 0; k < K; k++) acc += rx_row[r+k][r] * rx_col[c+k][c];
                        z_i[(r + c*H)*WD +: WD] = acc;
                    end
                z_valid_i = '1;
                zdone = 1;
            end else begin
                zdelay--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result monitor: pops the scoreboard on each new result, checks that
    // the result holds until taken and that c_valid_o drops after the take.
    // ------------------------------------------------------------------
    bit seen = 0;
    bit yumi_prev = 0;
    int hold_cnt = 0;
    logic [WD*H*W-1:0] held;

    always @(negedge clk) begin : p_monitor
        if (yumi_prev) chk("c_valid_fall", c_valid_o, 1'b0);
        if (c_valid_o === 1'b1 && !yumi_prev) begin
            if (!seen) begin
                seen = 1;
                held = c_o;
                hold_cnt = yumi_hold;
                chk("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) chk("c_o", c_o, sb_q.pop_front());
            end else begin
                chk("c_o_stable", c_o, held);
            end
            if (hold_cnt == 0) c_yumi_i = 1'b1;
            else begin
                hold_cnt--;
                c_yumi_i = 1'b0;
            end
        end else begin
            seen = 0;
            c_yumi_i = 1'b0;
        end
        yumi_prev = c_yumi_i;
    end

    // mode: 0 normal, 1 timeout, 2 start poked during DONE, 3 reset mid-FEED
    task automatic run_job(input int mode);
        int guard;
        int wait_cycles;
        int poke;
        int acc;
        logic [WD*H*W-1:0] expc;
        guard = 0;
        while (ready_o !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_start", ready_o, 1'b1);
        expc = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                acc = 0;
                for (int k = 0; k < K; k++) acc += cur_a[r][k] * cur_b[k][c];
                expc[(r + c*H)*WD +: WD] = acc;
            end
        for (int r = 0; r < H; r++)
            for (int k = 0; k < K; k++) a_i[(r + k*H)*WD +: WD] = cur_a[r][k];
        for (int k = 0; k < K; k++)
            for (int c = 0; c < W; c++) b_i[(k + c*K)*WD +: WD] = cur_b[k][c];
        suppress_z = (mode == 1);
        if (mode == 0 || mode == 2) sb_q.push_back(expc);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_i = {$urandom, $urandom, $urandom, $urandom};
        b_i = {$urandom, $urandom, $urandom, $urandom};
        chk("flush_cycle", {flush_o, en_o, row_valid_o, col_valid_o, err_o, ready_o, c_valid_o},
            {{H{1'b1}}, 1'b1, {H{1'b0}}, {W{1'b0}}, 3'b000});
        @(negedge clk);
        chk("first_feed", {flush_o, en_o, row_valid_o[0], col_valid_o[0]}, {{H{1'b0}}, 3'b111});
        if (mode == 3) begin
            guard = 0;
            while (row_valid_o !== '1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            chk("reach_t1", row_valid_o, {H{1'b1}});
            reset_i = 1'b1;
            @(negedge clk);
            chk_reset("reset_mid_feed");
            @(negedge clk);
            reset_i = 1'b0;
            sb_q.delete();
            return;
        end
        guard = 0;
        wait_cycles = 0;
        poke = 0;
        while (ready_o !== 1'b1 && guard < 400) begin
            if (en_o && row_valid_o == '0 && col_valid_o == '0 && flush_o == '0 && z_yumi_o == '0)
                wait_cycles++;
            if (mode == 2 && c_valid_o) begin
                if (poke == 0) start_i = 1'b1;
                else if (poke < 4)
                    chk("start_ignored_in_done", {ready_o, flush_o, c_valid_o}, {1'b0, {H{1'b0}}, 1'b1});
                if (poke == 3) start_i = 1'b0;
                if (poke < 4) poke++;
            end
            @(negedge clk);
            guard++;
        end
        start_i = 1'b0;
        chk("job_complete", guard < 400, 1'b1);
        if (mode == 1) begin
            chk("wait_cycles", wait_cycles, TO);
            chk("err_set", err_o, 1'b1);
        end else begin
            chk("err_clear", err_o, 1'b0);
        end
        suppress_z = 0;
    endtask

    task automatic set_mats(input int a00, input int a01, input int a10, input int a11,
                            input int b00, input int b01, input int b10, input int b11);
        cur_a[0][0] = a00; cur_a[0][1] = a01; cur_a[1][0] = a10; cur_a[1][1] = a11;
        cur_b[0][0] = b00; cur_b[0][1] = b01; cur_b[1][0] = b10; cur_b[1][1] = b11;
    endtask

    task automatic set_random();
        for (int r = 0; r < H; r++) for (int k = 0; k < K; k++) cur_a[r][k] = rnd_val();
        for (int k = 0; k < K; k++) for (int c = 0; c < W; c++) cur_b[k][c] = rnd_val();
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        a_i = '0;
        b_i = '0;
        set_mats(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_reset("reset_state");
        reset_i = 1'b0;
        @(negedge clk);

        set_mats(13, 45, 6, 27, 83, 9, 22, 1);
        run_job(0);
        set_mats(-37, 44, 10, 960, 83, 99, 22, -1);
        run_job(0);

        stall_mode = 2;
        set_mats(13, 45, 6, 27, 83, 9, 22, 1);
        run_job(0);
        stall_mode = 0;

        for (int j = 0; j < 16; j++) begin
            stall_mode = int'($urandom_range(1));
            yumi_hold  = int'($urandom_range(3));
            set_random();
            run_job(0);
        end
        stall_mode = 0;
        yumi_hold  = 0;

        set_random();
        run_job(1);
        set_random();
        run_job(0);

        yumi_hold = 5;
        set_random();
        run_job(2);
        yumi_hold = 0;

        set_random();
        run_job(3);
        set_mats(-37, 44, 10, 960, 83, 99, 22, -1);
        run_job(0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
